// File: rtl/ps2_key_tx_if.sv
// Key-event input and PS/2 wire-side outputs of ps2_key_tx.
// The master side (hps_io) drives ps2_key; the slave side (ps2_key_tx) drives the rest.
interface ps2_key_tx_if;
  logic [10:0] ps2_key;
  logic        ps2_clk;
  logic        ps2_data;
  logic        busy;
  logic        overflow;

  modport master (output ps2_key, input ps2_clk, ps2_data, busy, overflow);
  modport slave  (input ps2_key, output ps2_clk, ps2_data, busy, overflow);
endinterface

// File: rtl/ps2_key_tx.sv
// Turns hps_io ps2_key toggle events into 1-3 byte scancode sequences and
// serialises them from a byte FIFO as device-side 11-bit PS/2 frames.
module ps2_key_tx #(
  parameter int unsigned CLK_HZ     = 28636360,
  parameter int unsigned PS2_HZ     = 12500,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned GAP_BITS   = 4
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  ps2_key_tx_if.slave bus
);
  localparam int unsigned HALF_DIV   = CLK_HZ / (2 * PS2_HZ);
  localparam int unsigned GAP_LEN    = GAP_BITS * 2 * HALF_DIV;
  localparam int unsigned DIV_MAX    = (GAP_LEN > HALF_DIV) ? GAP_LEN : HALF_DIV;
  localparam int unsigned DIV_W      = $clog2(DIV_MAX + 1);
  localparam int unsigned AW         = $clog2(FIFO_DEPTH);
  localparam int unsigned CW         = AW + 1;
  localparam int unsigned GAP_LAST_I = (GAP_LEN == 0) ? 0 : GAP_LEN - 1;

  localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [DIV_W-1:0] GAP_LAST  = DIV_W'(GAP_LAST_I);
  localparam logic [CW-1:0]    DEPTH_C   = CW'(FIFO_DEPTH);

  if (HALF_DIV < 2) begin : g_bad_div
    $error("ps2_key_tx: CLK_HZ/(2*PS2_HZ) must be at least 2");
  end
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("ps2_key_tx: FIFO_DEPTH must be a power of 2 and at least 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    BIT_HI,
    BIT_LO,
    GAP
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       bit_idx_q, bit_idx_d;
  logic [10:0]      shift_q, shift_d;
  logic             clk_q, clk_d;
  logic             data_q, data_d;
  logic             tog_q, tog_d;
  logic             ovf_q, ovf_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [7:0]       mem_d [FIFO_DEPTH];

  logic             ev;
  logic [2:0][7:0]  ev_bytes;
  logic [1:0]       ev_len;
  logic [CW-1:0]    free_slots;
  logic             accept;
  logic             pop;
  logic [7:0]       head;

  // Event detection and scancode expansion
  always_comb begin
    tog_d    = bus.ps2_key[10];
    ev       = bus.ps2_key[10] ^ tog_q;
    ev_bytes = '0;
    ev_len   = 2'd1;
    unique case ({bus.ps2_key[9], bus.ps2_key[8]})
      2'b10: begin
        ev_bytes[0] = bus.ps2_key[7:0];
        ev_len      = 2'd1;
      end
      2'b11: begin
        ev_bytes[0] = 8'hE0;
        ev_bytes[1] = bus.ps2_key[7:0];
        ev_len      = 2'd2;
      end
      2'b00: begin
        ev_bytes[0] = 8'hF0;
        ev_bytes[1] = bus.ps2_key[7:0];
        ev_len      = 2'd2;
      end
      default: begin
        ev_bytes[0] = 8'hE0;
        ev_bytes[1] = 8'hF0;
        ev_bytes[2] = bus.ps2_key[7:0];
        ev_len      = 2'd3;
      end
    endcase
  end

  // Admission uses the pre-pop occupancy so a same-cycle pop never frees room
  // for a sequence that would otherwise be dropped.
  always_comb begin
    free_slots = DEPTH_C - count_q;
    accept     = ev && (free_slots >= CW'(ev_len));
    ovf_d      = ovf_q | (ev & ~accept);
    head       = mem_q[rd_ptr_q];

    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    if (accept) begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (2'(i) < ev_len) begin
          mem_d[wr_ptr_q + AW'(i)] = ev_bytes[i];
        end
      end
      wr_ptr_d = wr_ptr_q + AW'(ev_len);
    end

    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (accept ? CW'(ev_len) : '0) - (pop ? CW'(1) : '0);
  end

  // Transmitter: data only moves on BIT_HI entry, receiver samples on ps2_clk fall
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    clk_d     = clk_q;
    data_d    = data_q;
    pop       = 1'b0;

    unique case (state_q)
      IDLE: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (count_q != '0) begin
          pop       = 1'b1;
          shift_d   = {1'b1, ~^head, head, 1'b0};
          data_d    = 1'b0;
          bit_idx_d = '0;
          div_d     = '0;
          state_d   = BIT_HI;
        end
      end
      BIT_HI: begin
        if (div_q == HALF_LAST) begin
          div_d   = '0;
          clk_d   = 1'b0;
          state_d = BIT_LO;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      BIT_LO: begin
        if (div_q == HALF_LAST) begin
          div_d = '0;
          clk_d = 1'b1;
          if (bit_idx_q < 4'd10) begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b1, shift_q[10:1]};
            data_d    = shift_q[1];
            state_d   = BIT_HI;
          end else begin
            data_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      GAP: begin
        clk_d  = 1'b1;
        data_d = 1'b1;
        if (div_q == GAP_LAST) begin
          div_d   = '0;
          state_d = IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '1;
      clk_q     <= 1'b1;
      data_q    <= 1'b1;
      tog_q     <= bus.ps2_key[10];
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      clk_q     <= clk_d;
      data_q    <= data_d;
      tog_q     <= tog_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    mem_q <= mem_d;
  end

  assign bus.ps2_clk  = clk_q;
  assign bus.ps2_data = data_q;
  assign bus.busy     = (state_q != IDLE) || (count_q != '0);
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_ps2_key_tx.sv
// Randomised bench for ps2_key_tx: a queue-based reference model predicts the
// byte stream and status flags, and a wire-level PS/2 receiver decodes the DUT output.
module tb_ps2_key_tx;
  localparam int unsigned CLK_HZ     = 1000;
  localparam int unsigned PS2_HZ     = 100;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned GAP_BITS   = 1;
  localparam int unsigned HALF_DIV   = 5;
  // cycles the transmitter stays out of IDLE per byte: 11 bits of 2 half periods plus the gap
  localparam int unsigned TX_SPAN    = 22 * HALF_DIV + 2 * GAP_BITS * HALF_DIV;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;

  ps2_key_tx_if bus ();

  ps2_key_tx #(
    .CLK_HZ    (CLK_HZ),
    .PS2_HZ    (PS2_HZ),
    .FIFO_DEPTH(FIFO_DEPTH),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model
  logic [7:0] fifo_m [$];
  logic [7:0] exp_tx [$];
  int         tx_timer = 0;
  logic       tog_ref  = 1'b0;
  logic       exp_ovf  = 1'b0;

  // wire-level receiver
  int         cyc = 0;
  logic       mon_prev_clk = 1'b1;
  int         mon_nbits = 0;
  logic [10:0] mon_bits = '0;
  int         mon_fall_cyc = 0;
  int         mon_rise_cyc = 0;
  int         mon_first_fall = 0;
  int         rx_count = 0;
  logic [10:0] last_frame = '0;
  logic [7:0] rx_log [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit seq_wellformed(input logic [7:0] q[$]);
    int i = 0;
    while (i < q.size()) begin
      if (q[i] == 8'hE0) i++;
      if (i < q.size() && q[i] == 8'hF0) i++;
      if (i >= q.size() || q[i] == 8'hE0 || q[i] == 8'hF0) return 1'b0;
      i++;
    end
    return 1'b1;
  endfunction

  task automatic model_edge();
    logic [7:0] seq [$];
    int         free;
    logic       ev;
    if (!reset_n) begin
      tog_ref  = bus.ps2_key[10];
      fifo_m.delete();
      exp_tx.delete();
      tx_timer  = 0;
      exp_ovf   = 1'b0;
      mon_nbits = 0;
      return;
    end
    ev      = (bus.ps2_key[10] != tog_ref);
    tog_ref = bus.ps2_key[10];
    free    = FIFO_DEPTH - fifo_m.size();
    if (tx_timer == 0 && fifo_m.size() != 0) begin
      exp_tx.push_back(fifo_m.pop_front());
      tx_timer = TX_SPAN;
    end else if (tx_timer > 0) begin
      tx_timer--;
    end
    if (ev) begin
      if (bus.ps2_key[8]) seq.push_back(8'hE0);
      if (!bus.ps2_key[9]) seq.push_back(8'hF0);
      seq.push_back(bus.ps2_key[7:0]);
      if (seq.size() <= free) begin
        foreach (seq[k]) fifo_m.push_back(seq[k]);
      end else begin
        exp_ovf = 1'b1;
      end
    end
  endtask

  task automatic monitor();
    logic       c;
    logic [8:0] exp_b;
    cyc++;
    c = bus.ps2_clk;
    if (mon_prev_clk && !c) begin
      if (mon_nbits == 0) mon_first_fall = cyc;
      else check("clk_high", cyc - mon_rise_cyc, HALF_DIV);
      if (mon_nbits < 11) mon_bits[mon_nbits] = bus.ps2_data;
      mon_nbits++;
      mon_fall_cyc = cyc;
    end else if (!mon_prev_clk && c && mon_nbits > 0) begin
      check("clk_low", cyc - mon_fall_cyc, HALF_DIV);
      mon_rise_cyc = cyc;
      if (mon_nbits == 11) begin
        check("start_bit", mon_bits[0], 1'b0);
        check("stop_bit", mon_bits[10], 1'b1);
        check("odd_parity", ^mon_bits[9:1], 1'b1);
        // first falling edge to last rising edge: the 110-cycle frame minus its first high phase
        check("frame_len", cyc - mon_first_fall, 21 * HALF_DIV);
        exp_b = (exp_tx.size() != 0) ? {1'b0, exp_tx.pop_front()} : 9'h100;
        check("rx_byte", {1'b0, mon_bits[8:1]}, exp_b);
        rx_log.push_back(mon_bits[8:1]);
        last_frame = mon_bits;
        rx_count++;
        mon_nbits = 0;
      end
    end
    mon_prev_clk = c;
    check("busy", bus.busy, (tx_timer != 0) || (fifo_m.size() != 0));
    check("overflow", bus.overflow, exp_ovf);
    if (tx_timer == 0) begin
      check("idle_clk", bus.ps2_clk, 1'b1);
      check("idle_data", bus.ps2_data, 1'b1);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    model_edge();
    @(negedge clk_sys);
    monitor();
  endtask

  task automatic send_event(input logic pressed, input logic ext, input logic [7:0] code);
    bus.ps2_key = {~bus.ps2_key[10], pressed, ext, code};
    tick();
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    while ((tx_timer != 0 || fifo_m.size() != 0) && k < budget) begin
      tick();
      k++;
    end
    repeat (3) tick();
    check({tag, "_drained"}, bus.busy, 1'b0);
    check({tag, "_pending"}, exp_tx.size(), 0);
  endtask

  task automatic wait_pop_cycle(input string tag, input int budget);
    int k = 0;
    while (tx_timer != 0 && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_pop_reached"}, tx_timer, 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int rx0;
    int k;
    bus.ps2_key = 11'h400;
    reset_n     = 1'b0;

    // reset with the strobe held high: no spurious event
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (30) tick();
    check("no_frame_after_reset", rx_count, 0);

    // single make code 1C
    send_event(1'b1, 1'b0, 8'h1C);
    wait_idle("press_1c", 400);
    check("frame_1c_bits", last_frame, 11'b1_0_00011100_0);
    check("frame_1c_count", rx_count, 1);

    // extended release 75
    rx_log.delete();
    send_event(1'b0, 1'b1, 8'h75);
    wait_idle("rel_ext_75", 600);
    check("rel_ext_len", rx_log.size(), 3);
    if (rx_log.size() == 3) begin
      check("rel_ext_b0", rx_log[0], 8'hE0);
      check("rel_ext_b1", rx_log[1], 8'hF0);
      check("rel_ext_b2", rx_log[2], 8'h75);
    end

    // three extended releases on consecutive cycles
    rx_log.delete();
    send_event(1'b0, 1'b1, 8'h6B);
    send_event(1'b0, 1'b1, 8'h74);
    send_event(1'b0, 1'b1, 8'h72);
    wait_idle("burst", 1500);
    check("burst_wellformed", seq_wellformed(rx_log), 1'b1);

    // event on the pop cycle with 1 free slot: dropped using pre-pop count
    do_reset();
    send_event(1'b0, 1'b1, 8'h11);
    send_event(1'b0, 1'b1, 8'h12);
    send_event(1'b1, 1'b1, 8'h13);
    wait_pop_cycle("full_m1", 300);
    check("full_m1_depth", fifo_m.size(), 7);
    send_event(1'b0, 1'b0, 8'h1C);
    check("ovf_prepop", bus.overflow, 1'b1);

    // reset during the low phase of bit 4
    k = 0;
    while (!(mon_nbits == 5 && bus.ps2_clk == 1'b0) && k < 400) begin
      tick();
      k++;
    end
    check("bit4_reached", mon_nbits, 5);
    do_reset();
    check("rst_mid_clk", bus.ps2_clk, 1'b1);
    check("rst_mid_data", bus.ps2_data, 1'b1);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_ovf", bus.overflow, 1'b0);
    rx0 = rx_count;
    repeat (300) tick();
    check("rst_mid_no_frames", rx_count, rx0);

    // event on the pop cycle with 2 free slots and N=2: accepted
    rx_log.delete();
    send_event(1'b1, 1'b0, 8'h21);
    send_event(1'b0, 1'b1, 8'h22);
    send_event(1'b0, 1'b1, 8'h23);
    wait_pop_cycle("two_free", 300);
    send_event(1'b1, 1'b1, 8'h24);
    check("two_free_ovf", bus.overflow, 1'b0);
    wait_idle("two_free", 2500);
    check("two_free_len", rx_log.size(), 9);
    if (rx_log.size() == 9) begin
      check("two_free_b7", rx_log[7], 8'hE0);
      check("two_free_b8", rx_log[8], 8'h24);
    end

    // randomised events with random spacing
    rx_log.delete();
    repeat (40) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 200);
      repeat (gap) tick();
      send_event(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 8'($urandom_range(1, 8'hDF)));
    end
    wait_idle("random", 6000);
    check("random_wellformed", seq_wellformed(rx_log), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
